// File: rtl/multicycle_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_fsm
//  Description : Control sequencer for a multicycle CPU. Walks each
//                instruction from FETCH to retire, drives the ALU op and
//                datapath enables, and counts retired instructions.
//                Optional macro ILLEGAL_TRAP_EN: when defined, an illegal
//                opcode in DECODE parks the sequencer in TRAP until reset.
//                When undefined, an illegal opcode retires like a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       instr_opcode,
    input  logic             mem_ready,
    input  logic             Beq_alu,
    output logic [3:0]       ALU_selection,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_ALU = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic             w_alu_legal;
    logic             w_is_nop;
    logic             w_is_r;
    logic             w_is_i;
    logic             w_is_lw;
    logic             w_is_sw;
    logic             w_is_beq;
    logic             w_is_j;

    // Opcode classification; R/I forms are only valid with a supported ALU op
    always_comb begin
        w_alu_legal = 1'b0;
        case (instr_opcode[3:0])
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0111, 4'b1001: w_alu_legal = 1'b1;
            default:                            w_alu_legal = 1'b0;
        endcase
    end

    assign w_is_nop = (instr_opcode == 6'b000000);
    assign w_is_r   = (instr_opcode[5:4] == 2'b01) && w_alu_legal;
    assign w_is_i   = (instr_opcode[5:4] == 2'b11) && w_alu_legal;
    assign w_is_lw  = (instr_opcode == 6'b100000);
    assign w_is_sw  = (instr_opcode == 6'b100001);
    assign w_is_beq = (instr_opcode == 6'b100010);
    assign w_is_j   = (instr_opcode == 6'b100011);

    // Next-state selection; memory states hold until mem_ready
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_r)                   w_next = S_EXEC_R;
                else if (w_is_i)              w_next = S_EXEC_I;
                else if (w_is_lw || w_is_sw)  w_next = S_ADDR;
                else if (w_is_beq)            w_next = S_BRANCH;
                else if (w_is_j)              w_next = S_JUMP;
                else if (w_is_nop)            w_next = S_FETCH;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_EXEC_R: w_next = S_WB_ALU;
            S_EXEC_I: w_next = S_WB_ALU;
            S_WB_ALU: w_next = S_FETCH;
            S_ADDR:   w_next = w_is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) w_next = S_WB_MEM;
            S_WB_MEM: w_next = S_FETCH;
            S_MEM_WR: if (mem_ready) w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // An instruction retires whenever the sequencer re-enters FETCH
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    // State and retired-instruction counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_count <= r_count + 1'b1;
        end
    end

    // Moore decode of datapath controls; reset forces everything to zero at once
    // so an in-flight memory strobe drops in the same cycle rst is asserted.
    always_comb begin
        ALU_selection = 4'b0000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_src        = 2'd0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read      = 1'b1;
                    alu_src_b     = 2'd1;
                    ALU_selection = 4'b0010;
                    ir_write      = mem_ready;
                    pc_write      = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b     = 2'd3;
                    ALU_selection = 4'b0010;
                end
                S_EXEC_R: begin
                    alu_src_a     = 1'b1;
                    ALU_selection = instr_opcode[3:0];
                end
                S_EXEC_I: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = 2'd2;
                    ALU_selection = instr_opcode[3:0];
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = ~instr_opcode[5];   // 01xxxx is R-type -> rd
                end
                S_ADDR: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = 2'd2;
                    ALU_selection = 4'b0010;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    ALU_selection = 4'b0011;
                    pc_src        = 2'd1;
                    pc_write      = Beq_alu;
                end
                S_JUMP: begin
                    pc_src   = 2'd2;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_out   = rst ? 4'd0 : r_state;
    assign instr_count = rst ? '0 : r_count;

endmodule
`default_nettype wire
